// File: rtl/matrix_scan_driver.sv
`timescale 1ns/1ps
// Row-scan driver for multi-colour LED matrices whose columns hang off a 74HC595 chain.
// Each row is cleared, shifted LSB first, latched and shown for DWELL ticks; frames are double-buffered.
module matrix_scan_driver #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int CHANNELS = 3,
  parameter int CLK_DIV  = 4,
  parameter int DWELL    = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         mode,
  input  logic [ROWS*CHANNELS*COLS-1:0] frame_i,
  output logic [ROWS-1:0]              row_o,
  output logic                         shcp,
  output logic                         stcp,
  output logic                         mr_n,
  output logic                         oe_n,
  output logic                         ds,
  output logic                         frame_done
);

  localparam int L     = CHANNELS * COLS;
  localparam int FW    = ROWS * L;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BIT_W = $clog2(2 * L);
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, LATCH, DISPLAY} state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic               clr_hi, clr_hi_n;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [DW_W-1:0]    dwell_cnt, dwell_cnt_n;
  logic [ROW_W-1:0]   row, row_n;
  logic [PL_W-1:0]    plane, plane_n;
  logic [FW-1:0]      sh_frame;
  logic               sh_mode;
  logic               snap;
  logic [L-1:0]       row_word, plane_mask;
  logic               cur_bit;
  logic [ROWS-1:0]    row_onehot, row_o_n;
  logic               shcp_n, stcp_n, mr_n_n, oe_n_n, ds_n, fd_n;
  logic               last_plane, last_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (div_cnt == DIV_W'(CLK_DIV - 1))
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_plane = !sh_mode || (plane == PL_W'(CHANNELS - 1));
  assign last_row   = (row == ROW_W'(ROWS - 1));

  // Chain word for the current row; in plane-sequential mode only the active plane survives.
  always_comb begin
    row_word   = '0;
    plane_mask = '0;
    row_onehot = '0;
    cur_bit    = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (row == ROW_W'(r)) begin
        row_word      = sh_frame[r*L +: L];
        row_onehot[r] = 1'b1;
      end
    end
    for (int p = 0; p < CHANNELS; p++)
      for (int c = 0; c < COLS; c++)
        plane_mask[p*COLS + c] = !sh_mode || (plane == PL_W'(p));
    for (int k = 0; k < L; k++)
      if ((bit_cnt >> 1) == BIT_W'(k))
        cur_bit = row_word[k] & plane_mask[k];
  end

  always_comb begin
    state_n     = state;
    clr_hi_n    = clr_hi;
    bit_cnt_n   = bit_cnt;
    dwell_cnt_n = dwell_cnt;
    row_n       = row;
    plane_n     = plane;
    snap        = 1'b0;
    fd_n        = 1'b0;
    row_o_n     = row_o;
    shcp_n      = shcp;
    stcp_n      = stcp;
    mr_n_n      = mr_n;
    oe_n_n      = oe_n;
    ds_n        = ds;
    case (state)
      IDLE: begin
        row_o_n = '0;
        shcp_n  = 1'b0;
        stcp_n  = 1'b0;
        mr_n_n  = 1'b0;
        oe_n_n  = 1'b1;
        ds_n    = 1'b0;
        if (enable) begin
          snap     = 1'b1;
          row_n    = '0;
          plane_n  = '0;
          clr_hi_n = 1'b0;
          state_n  = CLEAR;
        end
      end
      CLEAR: begin
        oe_n_n = 1'b1;
        if (!clr_hi) begin
          mr_n_n   = 1'b0;
          clr_hi_n = 1'b1;
        end else begin
          mr_n_n    = 1'b1;
          bit_cnt_n = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (!bit_cnt[0]) begin
          shcp_n = 1'b0;
          ds_n   = cur_bit;
        end else begin
          shcp_n = 1'b1;
        end
        if (bit_cnt == BIT_W'(2*L - 1))
          state_n = LATCH;
        else
          bit_cnt_n = bit_cnt + 1'b1;
      end
      LATCH: begin
        shcp_n      = 1'b0;
        ds_n        = 1'b0;
        stcp_n      = 1'b1;
        oe_n_n      = 1'b1;
        row_o_n     = row_onehot;
        dwell_cnt_n = '0;
        state_n     = DISPLAY;
      end
      DISPLAY: begin
        stcp_n = 1'b0;
        oe_n_n = 1'b0;
        if (dwell_cnt == DW_W'(DWELL - 1)) begin
          // oe_n stays low through this last tick; the following CLEAR tick blanks it.
          clr_hi_n = 1'b0;
          state_n  = CLEAR;
          if (!last_plane) begin
            plane_n = plane + 1'b1;
          end else begin
            plane_n = '0;
            if (last_row) begin
              row_n = '0;
              snap  = 1'b1;
              fd_n  = 1'b1;
            end else begin
              row_n = row + 1'b1;
            end
          end
        end else begin
          dwell_cnt_n = dwell_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && !enable) begin
      state_n = IDLE;
      row_n   = '0;
      plane_n = '0;
      snap    = 1'b0;
      fd_n    = 1'b0;
      row_o_n = '0;
      shcp_n  = 1'b0;
      stcp_n  = 1'b0;
      mr_n_n  = 1'b0;
      oe_n_n  = 1'b1;
      ds_n    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clr_hi    <= 1'b0;
      bit_cnt   <= '0;
      dwell_cnt <= '0;
      row       <= '0;
      plane     <= '0;
      sh_frame  <= '0;
      sh_mode   <= 1'b0;
      row_o     <= '0;
      shcp      <= 1'b0;
      stcp      <= 1'b0;
      mr_n      <= 1'b0;
      oe_n      <= 1'b1;
      ds        <= 1'b0;
    end else if (tick) begin
      state     <= state_n;
      clr_hi    <= clr_hi_n;
      bit_cnt   <= bit_cnt_n;
      dwell_cnt <= dwell_cnt_n;
      row       <= row_n;
      plane     <= plane_n;
      row_o     <= row_o_n;
      shcp      <= shcp_n;
      stcp      <= stcp_n;
      mr_n      <= mr_n_n;
      oe_n      <= oe_n_n;
      ds        <= ds_n;
      if (snap) begin
        sh_frame <= frame_i;
        sh_mode  <= mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_done <= 1'b0;
    else
      frame_done <= tick & fd_n;
  end

endmodule
